// File: rtl/onehot_encoder_pipe_if.sv
// Valid/ready bus between a one-hot producer, the onehot_encoder_pipe and its binary consumer.
// The producer/consumer side uses the master modport and the encoder uses the slave modport.
interface onehot_encoder_pipe_if #(
  parameter int N     = 10,
  parameter int CNT_W = 8
);
  localparam int W = $clog2(N);

  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_data;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_code;
  logic             out_zero;
  logic             out_multi;
  logic             err_clr;
  logic [CNT_W-1:0] err_count;

  modport master (
    output in_valid, in_data, out_ready, err_clr,
    input  in_ready, out_valid, out_code, out_zero, out_multi, err_count
  );

  modport slave (
    input  in_valid, in_data, out_ready, err_clr,
    output in_ready, out_valid, out_code, out_zero, out_multi, err_count
  );
endinterface

// File: rtl/onehot_encoder_pipe.sv
// Registered one-hot to binary encoder with valid/ready flow control and a saturating malformed-word counter.
// Define ONEHOT_ENC_DROP_ERR_EN to count malformed words without presenting them downstream.
module onehot_encoder_pipe #(
  parameter int N            = 10,
  parameter int PRIORITY_LSB = 1,
  parameter int CNT_W        = 8
) (
  input logic                   clk,
  input logic                   rst,
  onehot_encoder_pipe_if.slave  bus
);
  localparam int               W       = $clog2(N);
  localparam logic [N-1:0]     ONE_N   = {{(N-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [W-1:0]     dec_code;
  logic             dec_zero;
  logic             dec_multi;
  logic             accept;
  logic             malformed;
  logic             load;

  logic             out_valid_q, out_valid_d;
  logic [W-1:0]     out_code_q, out_code_d;
  logic             out_zero_q, out_zero_d;
  logic             out_multi_q, out_multi_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;

  // The last match written wins, so the scan direction picks the priority.
  always_comb begin
    dec_code = '0;
    if (PRIORITY_LSB != 0) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (bus.in_data[i]) dec_code = i[W-1:0];
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (bus.in_data[i]) dec_code = i[W-1:0];
      end
    end
    dec_zero  = ~|bus.in_data;
    dec_multi = |(bus.in_data & (bus.in_data - ONE_N));
  end

  assign bus.in_ready = !rst && (!out_valid_q || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;
  assign malformed    = accept && (dec_zero || dec_multi);

`ifdef ONEHOT_ENC_DROP_ERR_EN
  assign load = accept && !(dec_zero || dec_multi);
`else
  assign load = accept;
`endif

  always_comb begin
    out_valid_d = out_valid_q;
    out_code_d  = out_code_q;
    out_zero_d  = out_zero_q;
    out_multi_d = out_multi_q;
    if (load) begin
      out_valid_d = 1'b1;
      out_code_d  = dec_code;
`ifdef ONEHOT_ENC_DROP_ERR_EN
      out_zero_d  = 1'b0;
      out_multi_d = 1'b0;
`else
      out_zero_d  = dec_zero;
      out_multi_d = dec_multi;
`endif
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    // Clear takes effect before a same-cycle increment.
    err_count_d = bus.err_clr ? '0 : err_count_q;
    if (malformed && (err_count_d != CNT_MAX)) begin
      err_count_d = err_count_d + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_code_q  <= '0;
      out_zero_q  <= 1'b0;
      out_multi_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_code_q  <= out_code_d;
      out_zero_q  <= out_zero_d;
      out_multi_q <= out_multi_d;
      err_count_q <= err_count_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_code  = out_code_q;
  assign bus.out_zero  = out_zero_q;
  assign bus.out_multi = out_multi_q;
  assign bus.err_count = err_count_q;
endmodule

// File: tb/tb_onehot_encoder_pipe.sv
// Scoreboard bench for onehot_encoder_pipe: an LSB-priority and an MSB-priority instance see identical traffic.
// Expected words are queued at accept and compared while held at the output.
module tb_onehot_encoder_pipe;
  localparam int N     = 10;
  localparam int CNT_W = 8;
  localparam int W     = $clog2(N);
  localparam int CMAX  = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [W-1:0] code_l;
    logic [W-1:0] code_m;
    logic         zero;
    logic         multi;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   compared   = 0;
  int   mismatched = 0;

  exp_t sb[$];
  int   model_cnt = 0;
  int   next_cnt;
  exp_t mon_e;
  logic exp_rdy;

  onehot_encoder_pipe_if #(.N(N), .CNT_W(CNT_W)) bus_l ();
  onehot_encoder_pipe_if #(.N(N), .CNT_W(CNT_W)) bus_m ();

  assign bus_m.in_valid  = bus_l.in_valid;
  assign bus_m.in_data   = bus_l.in_data;
  assign bus_m.out_ready = bus_l.out_ready;
  assign bus_m.err_clr   = bus_l.err_clr;

  onehot_encoder_pipe #(.N(N), .PRIORITY_LSB(1), .CNT_W(CNT_W)) dut_lsb (
    .clk (clk),
    .rst (rst),
    .bus (bus_l)
  );

  onehot_encoder_pipe #(.N(N), .PRIORITY_LSB(0), .CNT_W(CNT_W)) dut_msb (
    .clk (clk),
    .rst (rst),
    .bus (bus_m)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [N-1:0] d);
    exp_t e;
    int   lo = -1;
    int   hi = 0;
    for (int i = 0; i < N; i++) begin
      if (d[i]) begin
        if (lo < 0) lo = i;
        hi = i;
      end
    end
    e.code_l = (lo < 0) ? '0 : lo[W-1:0];
    e.code_m = hi[W-1:0];
    e.zero   = ($countones(d) == 0);
    e.multi  = ($countones(d) > 1);
    return e;
  endfunction

  // Sampled mid-cycle so everything seen here is what the next rising edge will act on.
  always @(negedge clk) begin
    if (rst) begin
      checkOutput("in_ready_rst", {31'b0, bus_l.in_ready}, 0);
      sb.delete();
      model_cnt = 0;
    end else begin
      exp_rdy = (sb.size() == 0) || bus_l.out_ready;
      checkOutput("in_ready_l", {31'b0, bus_l.in_ready}, {31'b0, exp_rdy});
      checkOutput("in_ready_m", {31'b0, bus_m.in_ready}, {31'b0, exp_rdy});
      checkOutput("out_valid_l", {31'b0, bus_l.out_valid}, (sb.size() != 0) ? 1 : 0);
      checkOutput("out_valid_m", {31'b0, bus_m.out_valid}, (sb.size() != 0) ? 1 : 0);
      checkOutput("err_count_l", {24'b0, bus_l.err_count}, model_cnt);
      checkOutput("err_count_m", {24'b0, bus_m.err_count}, model_cnt);
      if (sb.size() != 0) begin
        mon_e = sb[0];
        checkOutput("code_lsb", {28'b0, bus_l.out_code}, {28'b0, mon_e.code_l});
        checkOutput("code_msb", {28'b0, bus_m.out_code}, {28'b0, mon_e.code_m});
        checkOutput("zero", {31'b0, bus_l.out_zero}, {31'b0, mon_e.zero});
        checkOutput("multi", {31'b0, bus_l.out_multi}, {31'b0, mon_e.multi});
        if (bus_l.out_ready) void'(sb.pop_front());
      end
      next_cnt = bus_l.err_clr ? 0 : model_cnt;
      if (bus_l.in_valid && exp_rdy) begin
        mon_e = model(bus_l.in_data);
        if ((mon_e.zero || mon_e.multi) && next_cnt < CMAX) next_cnt++;
`ifdef ONEHOT_ENC_DROP_ERR_EN
        if (!(mon_e.zero || mon_e.multi)) sb.push_back(mon_e);
`else
        sb.push_back(mon_e);
`endif
      end
      model_cnt = next_cnt;
    end
  end

  // Presents one word and returns just after the edge that accepted it.
  task automatic applyStimulus(input logic [N-1:0] d);
    logic ok = 1'b0;
    bus_l.in_valid = 1'b1;
    bus_l.in_data  = d;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      if (bus_l.in_ready) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
      end
    end
    bus_l.in_valid = 1'b0;
    checkOutput("accepted", {31'b0, ok}, 1);
  endtask

  function automatic logic [N-1:0] hot(input int i);
    logic [N-1:0] d = '0;
    d[i] = 1'b1;
    return d;
  endfunction

  initial begin
    rst             = 1'b1;
    bus_l.in_valid  = 1'b0;
    bus_l.in_data   = '0;
    bus_l.out_ready = 1'b1;
    bus_l.err_clr   = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    checkOutput("rst_out_valid", {31'b0, bus_l.out_valid}, 0);
    checkOutput("rst_out_code", {28'b0, bus_l.out_code}, 0);
    checkOutput("rst_out_zero", {31'b0, bus_l.out_zero}, 0);
    checkOutput("rst_out_multi", {31'b0, bus_l.out_multi}, 0);
    checkOutput("rst_err_count", {24'b0, bus_l.err_count}, 0);
    checkOutput("rst_in_ready", {31'b0, bus_l.in_ready}, 1);

    applyStimulus(10'b00_0000_1000);
    @(negedge clk);
    checkOutput("first_valid", {31'b0, bus_l.out_valid}, 1);
    checkOutput("first_code", {28'b0, bus_l.out_code}, 3);
    @(posedge clk);
    #1;

    for (int i = 0; i < N; i++) applyStimulus(hot(i));
    repeat (2) @(posedge clk);
    #1;

    bus_l.out_ready = 1'b0;
    applyStimulus(hot(5));
    bus_l.in_valid = 1'b1;
    bus_l.in_data  = hot(7);
    repeat (4) begin
      @(negedge clk);
      checkOutput("bp_in_ready", {31'b0, bus_l.in_ready}, 0);
      checkOutput("bp_code_held", {28'b0, bus_l.out_code}, 5);
    end
    @(posedge clk);
    #1 bus_l.out_ready = 1'b1;
    applyStimulus(hot(7));
    @(negedge clk);
    checkOutput("bp_code_next", {28'b0, bus_l.out_code}, 7);
    @(posedge clk);
    #1;

    applyStimulus(10'b10_0010_0000);
    @(negedge clk);
    checkOutput("multi_err_count", {24'b0, bus_l.err_count}, 1);
`ifndef ONEHOT_ENC_DROP_ERR_EN
    checkOutput("multi_code_lsb", {28'b0, bus_l.out_code}, 5);
    checkOutput("multi_code_msb", {28'b0, bus_m.out_code}, 9);
    checkOutput("multi_flag", {31'b0, bus_l.out_multi}, 1);
`endif
    @(posedge clk);
    #1;

    for (int i = 0; i < 300; i++) applyStimulus('0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("sat_err_count", {24'b0, bus_l.err_count}, CMAX);
    @(posedge clk);
    #1 bus_l.err_clr = 1'b1;
    applyStimulus('0);
    bus_l.err_clr = 1'b0;
    @(negedge clk);
    checkOutput("clr_and_inc", {24'b0, bus_l.err_count}, 1);
    @(posedge clk);
    #1;

    applyStimulus(hot(2));
    applyStimulus('0);
    applyStimulus(hot(4));
    bus_l.out_ready = 1'b0;
    repeat (2) begin
      @(negedge clk);
      checkOutput("held_valid", {31'b0, bus_l.out_valid}, 1);
      checkOutput("held_code", {28'b0, bus_l.out_code}, 4);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("midrst_valid", {31'b0, bus_l.out_valid}, 0);
    checkOutput("midrst_err", {24'b0, bus_l.err_count}, 0);
    bus_l.out_ready = 1'b1;
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
